// File: rtl/eru32_err_monitor.sv
// Error-characterisation stage for the approximate block carry-select adder.
// Compares approx_sum to the exact sum and reports per-window error statistics.
module eru32_err_monitor #(
    parameter int WIDTH    = 32,
    parameter int WIN_LOG2 = 10,
    parameter int ACC_W    = 48
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [WIDTH:0]     approx_sum,
    output logic               busy,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [WIN_LOG2:0]  err_count,
    output logic [ACC_W-1:0]   ed_sum,
    output logic [WIDTH:0]     ed_max
);

    localparam int STAGES = 2;
    localparam logic [WIN_LOG2:0] WIN  = {1'b1, {WIN_LOG2{1'b0}}};
    localparam logic [WIN_LOG2:0] LAST = {1'b0, {WIN_LOG2{1'b1}}};
    localparam logic [WIN_LOG2:0] ONE  = {{WIN_LOG2{1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, REPORT} state_t;

    typedef struct packed {
        logic [WIDTH:0] exact;
        logic [WIDTH:0] approx;
    } s1_t;

    state_t              state, state_nxt;
    logic [WIN_LOG2:0]   cnt;
    logic                accept, clr;
    logic [STAGES:1]     vld_pipe;
    s1_t                 s1;
    logic [WIDTH:0]      ed_nxt, ed2;
    logic [ACC_W:0]      sum_ext;

    assign accept = in_valid & in_ready;

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        busy      = 1'b0;
        res_valid = 1'b0;
        clr       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    clr       = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy     = 1'b1;
                in_ready = (cnt != WIN);
                if (in_valid && in_ready && cnt == LAST)
                    state_nxt = DRAIN;
            end
            DRAIN: begin
                busy = 1'b1;
                if (vld_pipe == '0)
                    state_nxt = REPORT;
            end
            REPORT: begin
                busy      = 1'b1;
                res_valid = 1'b1;
                if (res_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            vld_pipe <= '0;
        end else begin
            state    <= state_nxt;
            vld_pipe <= {vld_pipe[STAGES-1:1], accept};
            if (clr)
                cnt <= '0;
            else if (accept)
                cnt <= cnt + ONE;
        end
    end

    // Datapath registers only move on valid data; their valid bits gate all use.
    always_ff @(posedge clk) begin
        if (accept) begin
            s1.exact  <= {1'b0, a} + {1'b0, b};
            s1.approx <= approx_sum;
        end
        if (vld_pipe[1])
            ed2 <= ed_nxt;
    end

    assign ed_nxt  = (s1.exact >= s1.approx) ? s1.exact - s1.approx
                                             : s1.approx - s1.exact;
    assign sum_ext = {1'b0, ed_sum} + {{(ACC_W-WIDTH){1'b0}}, ed2};

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            err_count <= '0;
            ed_sum    <= '0;
            ed_max    <= '0;
        end else if (vld_pipe[STAGES]) begin
            if (ed2 != '0)
                err_count <= err_count + ONE;
            ed_sum <= sum_ext[ACC_W] ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
            if (ed2 > ed_max)
                ed_max <= ed2;
        end
    end

endmodule

// File: tb/tb_eru32_err_monitor.sv
// Scoreboard bench for eru32_err_monitor with a 4-sample window and 33-bit
// accumulator so saturation is reachable.
module tb_eru32_err_monitor;

    localparam int WIDTH    = 32;
    localparam int WIN_LOG2 = 2;
    localparam int ACC_W    = 33;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [WIDTH-1:0]   a = '0;
    logic [WIDTH-1:0]   b = '0;
    logic [WIDTH:0]     approx_sum = '0;
    logic               busy;
    logic               res_valid;
    logic               res_ready = 1'b1;
    logic [WIN_LOG2:0]  err_count;
    logic [ACC_W-1:0]   ed_sum;
    logic [WIDTH:0]     ed_max;

    eru32_err_monitor #(.WIDTH(WIDTH), .WIN_LOG2(WIN_LOG2), .ACC_W(ACC_W)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .a(a), .b(b), .approx_sum(approx_sum),
        .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
        .err_count(err_count), .ed_sum(ed_sum), .ed_max(ed_max)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] err;
        logic [63:0] sum;
        logic [63:0] mx;
    } exp_t;

    exp_t        q[$];
    exp_t        ve[3];
    logic [31:0] va[3][4];
    logic [31:0] vb[3][4];
    logic [32:0] vx[3][4];
    int          n_chk  = 0;
    int          n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h required %h", nm, act, req);
    endtask

    task automatic timeout(input string nm);
        n_chk++;
        $display("FAIL %s: timed out waiting for handshake", nm);
    endtask

    // Monitor: every cycle a result is presented it must match the head of the queue.
    always @(negedge clk) begin
        if (!rst && res_valid) begin
            if (q.size() == 0) begin
                timeout("unexpected_result");
            end else begin
                chk("err_count", 64'(err_count), q[0].err);
                chk("ed_sum",    64'(ed_sum),    q[0].sum);
                chk("ed_max",    64'(ed_max),    q[0].mx);
                chk("in_ready_in_report", 64'(in_ready), 64'd0);
                if (res_ready) void'(q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input int w, input int i);
        int   t;
        logic acc;
        t = 0;
        acc = 1'b0;
        a = va[w][i];
        b = vb[w][i];
        approx_sum = vx[w][i];
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            acc = in_ready;
            tick();
            t++;
        end while (!acc && t < 100);
        if (!acc) timeout("accept");
        in_valid = 1'b0;
    endtask

    task automatic wait_result(input int w);
        int t;
        t = 0;
        while (q.size() != 0 && t < 60) begin
            tick();
            t++;
        end
        if (q.size() != 0) begin
            timeout("result");
            q.delete();
        end
        chk("busy_idle",    64'(busy),   64'd0);
        chk("ed_max_held",  64'(ed_max), ve[w].mx);
    endtask

    task automatic run_window(input int w, input bit gap, input bit mid_start);
        q.push_back(ve[w]);
        pulse_start();
        chk("busy_run",     64'(busy),     64'd1);
        chk("in_ready_run", 64'(in_ready), 64'd1);
        for (int i = 0; i < 4; i++) begin
            send(w, i);
            if (gap) tick();
            if (mid_start && i == 1) pulse_start();
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_in_ready"},  64'(in_ready),  64'd0);
        chk({tag, "_busy"},      64'(busy),      64'd0);
        chk({tag, "_res_valid"}, 64'(res_valid), 64'd0);
        chk({tag, "_err_count"}, 64'(err_count), 64'd0);
        chk({tag, "_ed_sum"},    64'(ed_sum),    64'd0);
        chk({tag, "_ed_max"},    64'(ed_max),    64'd0);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            va[0][i] = 32'h1234_5678; vb[0][i] = 32'h0000_FFFF; vx[0][i] = 33'h0_1235_5677;
            va[1][i] = 32'h0000_00FF; vb[1][i] = 32'h0000_0001;
        end
        vx[1][0] = 33'h100; vx[1][1] = 33'h000; vx[1][2] = 33'h1FF; vx[1][3] = 33'h100;
        va[2][0] = 32'hFFFF_FFFF; vb[2][0] = 32'hFFFF_FFFF; vx[2][0] = 33'h0;
        va[2][1] = 32'h0;         vb[2][1] = 32'h0;         vx[2][1] = 33'h0;
        va[2][2] = 32'hFFFF_FFFF; vb[2][2] = 32'hFFFF_FFFF; vx[2][2] = 33'h0;
        va[2][3] = 32'h1;         vb[2][3] = 32'h2;         vx[2][3] = 33'h3;
        ve[0] = '{64'd0, 64'd0,            64'd0};
        ve[1] = '{64'd2, 64'h1FF,          64'h100};
        ve[2] = '{64'd2, 64'h1_FFFF_FFFF,  64'h1_FFFF_FFFE};

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk_zero("reset");

        run_window(0, 1'b0, 1'b0);
        wait_result(0);
        run_window(1, 1'b0, 1'b0);
        wait_result(1);
        run_window(2, 1'b0, 1'b0);
        wait_result(2);

        // Gaps on input plus a 5-cycle stall on the result.
        res_ready = 1'b0;
        run_window(1, 1'b1, 1'b0);
        begin
            int t;
            t = 0;
            while (!res_valid && t < 60) begin
                tick();
                t++;
            end
            if (!res_valid) timeout("res_valid_stall");
        end
        repeat (5) tick();
        res_ready = 1'b1;
        wait_result(1);

        run_window(1, 1'b0, 1'b1);
        wait_result(1);

        // Reset with three samples of a saturating window in flight.
        pulse_start();
        for (int i = 0; i < 3; i++) send(2, i);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_zero("midrst");
        repeat (4) tick();
        chk("midrst_ed_sum_late", 64'(ed_sum), 64'd0);
        run_window(1, 1'b0, 1'b0);
        wait_result(1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
